// File: rtl/mux8_rr_arbiter.sv
// Eight-source round-robin arbiter/mux with per-grant burst limit and valid/ready output.
// Optional stall timeout enabled by defining MUX_ARB_TIMEOUT_EN.
module mux8_rr_arbiter #(
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  req,
  input  logic [31:0] D0,
  input  logic [31:0] D1,
  input  logic [31:0] D2,
  input  logic [31:0] D3,
  input  logic [31:0] D4,
  input  logic [31:0] D5,
  input  logic [31:0] D6,
  input  logic [31:0] D7,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  output logic [7:0]  grant,
  output logic [2:0]  sel,
  output logic        timeout_evt
);

  localparam int unsigned N  = 8;
  localparam int unsigned SW = 3;
  localparam int unsigned CW = 4;
  localparam int unsigned BW = 5;

  typedef enum logic {ARB = 1'b0, BUSY = 1'b1} state_t;

  if (MAX_BURST < 1 || MAX_BURST > 16) begin : g_bad_burst
    $error("MAX_BURST out of range 1..16");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("TIMEOUT out of range 1..255");
  end

  state_t        state, state_next;
  logic          armed;
  logic [SW-1:0] last, last_next, sel_next, winner;
  logic [N-1:0]  grant_next;
  logic [CW-1:0] count, count_next;
  logic [BW-1:0] burst_inc;
  logic          found, transfer, release_now, timeout_hit;

`ifdef MUX_ARB_TIMEOUT_EN
  logic [7:0] stall, stall_next, stall_inc;
  logic       evt_next;
  assign stall_inc   = stall + 8'd1;
  assign timeout_hit = (state == BUSY) && out_valid && !out_ready && (stall_inc == 8'(TIMEOUT));
`else
  assign timeout_hit = 1'b0;
  assign timeout_evt = 1'b0;
`endif

  // Data path follows the registered owner even while arbitrating.
  always_comb begin
    out_data = D0;
    case (sel)
      3'd0: out_data = D0;
      3'd1: out_data = D1;
      3'd2: out_data = D2;
      3'd3: out_data = D3;
      3'd4: out_data = D4;
      3'd5: out_data = D5;
      3'd6: out_data = D6;
      3'd7: out_data = D7;
      default: out_data = D0;
    endcase
  end

  assign out_valid = (state == BUSY) && req[sel];
  assign transfer  = out_valid && out_ready;
  assign burst_inc = BW'(count) + BW'(1);

  // Rotating priority search starting just after the previous owner.
  always_comb begin
    found  = 1'b0;
    winner = last;
    for (int i = 1; i <= int'(N); i++) begin
      if (!found && req[SW'(last + SW'(i))]) begin
        found  = 1'b1;
        winner = SW'(last + SW'(i));
      end
    end
  end

  always_comb begin
    state_next  = state;
    grant_next  = grant;
    sel_next    = sel;
    last_next   = last;
    count_next  = count;
    release_now = 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
    stall_next  = stall;
    evt_next    = 1'b0;
`endif
    case (state)
      ARB: begin
        if (armed && found) begin
          state_next = BUSY;
          grant_next = N'(1) << winner;
          sel_next   = winner;
          last_next  = winner;
          count_next = '0;
`ifdef MUX_ARB_TIMEOUT_EN
          stall_next = '0;
`endif
        end
      end
      BUSY: begin
        if (transfer) begin
          count_next = count + CW'(1);
        end
`ifdef MUX_ARB_TIMEOUT_EN
        if (transfer) begin
          stall_next = '0;
        end else if (out_valid) begin
          stall_next = stall_inc;
        end
`endif
        release_now = !req[sel] || (transfer && burst_inc == BW'(MAX_BURST)) || timeout_hit;
        if (release_now) begin
          state_next = ARB;
          grant_next = '0;
          count_next = '0;
`ifdef MUX_ARB_TIMEOUT_EN
          stall_next = '0;
          evt_next   = timeout_hit;
`endif
        end
      end
      default: state_next = ARB;
    endcase
  end

  // armed holds off arbitration for the first edge after reset release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ARB;
      armed       <= 1'b0;
      grant       <= '0;
      sel         <= '0;
      last        <= 3'd7;
      count       <= '0;
`ifdef MUX_ARB_TIMEOUT_EN
      stall       <= '0;
      timeout_evt <= 1'b0;
`endif
    end else begin
      state       <= state_next;
      armed       <= 1'b1;
      grant       <= grant_next;
      sel         <= sel_next;
      last        <= last_next;
      count       <= count_next;
`ifdef MUX_ARB_TIMEOUT_EN
      stall       <= stall_next;
      timeout_evt <= evt_next;
`endif
    end
  end

endmodule
